// File: rtl/wb_write_buffer_if.sv
// Bus bundle for the register-file write buffer: producer handshake,
// register-file drain port and forwarding lookups.
interface wb_write_buffer_if #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
);
  logic          in_valid;
  logic          in_ready;
  logic [4:0]    in_wa;
  logic [31:0]   in_wd;
  logic          drain_en;
  logic          rf_we;
  logic [4:0]    rf_wa;
  logic [31:0]   rf_wd;
  logic [4:0]    ra1;
  logic [4:0]    ra2;
  logic          fwd1_hit;
  logic [31:0]   fwd1_data;
  logic          fwd2_hit;
  logic [31:0]   fwd2_data;
  logic [AW:0]   count;

  modport slave (
    input  in_valid, in_wa, in_wd, drain_en, ra1, ra2,
    output in_ready, rf_we, rf_wa, rf_wd,
    output fwd1_hit, fwd1_data, fwd2_hit, fwd2_data, count
  );

  modport master (
    output in_valid, in_wa, in_wd, drain_en, ra1, ra2,
    input  in_ready, rf_we, rf_wa, rf_wd,
    input  fwd1_hit, fwd1_data, fwd2_hit, fwd2_data, count
  );
endinterface

// File: rtl/wb_write_buffer.sv
// Register writeback FIFO: queues writes, drains one per cycle into the
// register file write port, and forwards queued values to readers.
module wb_write_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic              clk,
  input  logic              rst,
  wb_write_buffer_if.slave  bus
);

  localparam logic [AW:0] LP_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] LP_ZERO = (AW+1)'(0);

  logic [4:0]       r_wa [DEPTH];
  logic [31:0]      r_wd [DEPTH];
  logic [DEPTH-1:0] r_vld;
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;

  logic             w_full;
  logic             w_empty;
  logic             w_store;
  logic             w_pop;
  logic [DEPTH-1:0] w_set;
  logic [DEPTH-1:0] w_clr;
  logic [32:0]      w_fwd1;
  logic [32:0]      w_fwd2;

  // Oldest-to-newest scan so the newest matching entry overwrites earlier hits.
  function automatic logic [32:0] fwd_lookup(
    input logic [4:0]       ra,
    input logic [AW-1:0]    rd_ptr,
    input logic [DEPTH-1:0] vld,
    input logic [4:0]       wa [DEPTH],
    input logic [31:0]      wd [DEPTH]
  );
    logic [32:0]   res;
    logic [AW-1:0] idx;
    res = 33'd0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + AW'(i);
      res = (vld[idx] && (wa[idx] == ra) && (ra != 5'd0)) ? {1'b1, wd[idx]} : res;
    end
    return res;
  endfunction

  assign w_full  = (r_count == LP_FULL);
  assign w_empty = (r_count == LP_ZERO);
  // Register 0 writes complete the handshake but are never stored.
  assign w_store = bus.in_valid & ~w_full & (bus.in_wa != 5'd0);
  assign w_pop   = bus.drain_en & ~w_empty;

  assign bus.in_ready  = ~w_full;
  assign bus.rf_we     = w_pop;
  assign bus.rf_wa     = w_empty ? 5'd0  : r_wa[r_rd_ptr];
  assign bus.rf_wd     = w_empty ? 32'd0 : r_wd[r_rd_ptr];
  assign bus.count     = r_count;

  // Forwarding lookups for both read ports.
  always_comb begin
    w_fwd1 = fwd_lookup(bus.ra1, r_rd_ptr, r_vld, r_wa, r_wd);
    w_fwd2 = fwd_lookup(bus.ra2, r_rd_ptr, r_vld, r_wa, r_wd);
  end

  assign bus.fwd1_hit  = w_fwd1[32];
  assign bus.fwd1_data = w_fwd1[31:0];
  assign bus.fwd2_hit  = w_fwd2[32];
  assign bus.fwd2_data = w_fwd2[31:0];

  // One-hot valid-bit set/clear masks for the stored push and the pop.
  always_comb begin
    w_set = {DEPTH{1'b0}};
    w_clr = {DEPTH{1'b0}};
    if (w_store) begin
      w_set[r_wr_ptr] = 1'b1;
    end else begin
      w_set = {DEPTH{1'b0}};
    end
    if (w_pop) begin
      w_clr[r_rd_ptr] = 1'b1;
    end else begin
      w_clr = {DEPTH{1'b0}};
    end
  end

  // Queue storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_count  <= LP_ZERO;
      r_vld    <= {DEPTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        r_wa[i] <= 5'd0;
        r_wd[i] <= 32'd0;
      end
    end else begin
      if (w_store) begin
        r_wa[r_wr_ptr] <= bus.in_wa;
        r_wd[r_wr_ptr] <= bus.in_wd;
        r_wr_ptr       <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_vld <= (r_vld & ~w_clr) | w_set;
      case ({w_store, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_write_buffer.sv
// Scoreboard bench for wb_write_buffer: directed scenarios then random traffic,
// checked against a queue-based reference of the buffer contents.
module tb_wb_write_buffer;

  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic clk;
  logic rst;
  int   errors;
  int   checks;
  logic tb_ready;
  logic [36:0] sb_q [$];

  wb_write_buffer_if #(.DEPTH(DEPTH), .AW(AW)) bus ();

  wb_write_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Newest queued entry for ra wins; register 0 never matches.
  function automatic logic [32:0] ref_fwd(input logic [4:0] ra);
    for (int i = int'(sb_q.size()) - 1; i >= 0; i--) begin
      if (ra != 5'd0 && sb_q[i][36:32] == ra) return {1'b1, sb_q[i][31:0]};
    end
    return 33'd0;
  endfunction

  // Monitor: compares every output mid-cycle and retires drained writes in order.
  always @(negedge clk) begin
    int n;
    logic [32:0] f1, f2;
    logic [36:0] e;
    if (!rst) begin
      tb_ready = 1'b1;
    end else begin
      n  = sb_q.size();
      f1 = ref_fwd(bus.ra1);
      f2 = ref_fwd(bus.ra2);
      chk("in_ready", {31'd0, bus.in_ready}, {31'd0, n != DEPTH});
      chk("count", {29'd0, bus.count}, 32'(n));
      chk("rf_we", {31'd0, bus.rf_we}, {31'd0, bus.drain_en && n != 0});
      chk("fwd1_hit", {31'd0, bus.fwd1_hit}, {31'd0, f1[32]});
      chk("fwd1_data", bus.fwd1_data, f1[31:0]);
      chk("fwd2_hit", {31'd0, bus.fwd2_hit}, {31'd0, f2[32]});
      chk("fwd2_data", bus.fwd2_data, f2[31:0]);
      tb_ready = (n != DEPTH);
      if (bus.rf_we) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL drain_order: rf_we=1 but expected no queued write at %0t", $time);
        end else begin
          e = sb_q.pop_front();
          chk("rf_wa", {27'd0, bus.rf_wa}, {27'd0, e[36:32]});
          chk("rf_wd", bus.rf_wd, e[31:0]);
        end
      end else if (n == 0) begin
        chk("rf_wa_empty", {27'd0, bus.rf_wa}, 32'd0);
        chk("rf_wd_empty", bus.rf_wd, 32'd0);
      end
    end
  end

  // One cycle: record what the posedge accepts, then apply the next inputs.
  task automatic drive(input logic v, input logic [4:0] wa, input logic [31:0] wd,
                       input logic de, input logic [4:0] a1, input logic [4:0] a2);
    @(posedge clk);
    if (rst && bus.in_valid && tb_ready && bus.in_wa != 5'd0)
      sb_q.push_back({bus.in_wa, bus.in_wd});
    #1;
    bus.in_valid = v;
    bus.in_wa    = wa;
    bus.in_wd    = wd;
    bus.drain_en = de;
    bus.ra1      = a1;
    bus.ra2      = a2;
  endtask

  initial begin
    errors   = 0;
    checks   = 0;
    tb_ready = 1'b1;
    rst      = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_wa    = 5'd0;
    bus.in_wd    = 32'd0;
    bus.drain_en = 1'b0;
    bus.ra1      = 5'd0;
    bus.ra2      = 5'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("idle_count", {29'd0, bus.count}, 32'd0);
    chk("idle_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("idle_rf_we", {31'd0, bus.rf_we}, 32'd0);
    chk("idle_hit", {30'd0, bus.fwd1_hit, bus.fwd2_hit}, 32'd0);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0);

    // Single write with immediate drain.
    drive(1'b1, 5'd5, 32'h1234_5678, 1'b1, 5'd0, 5'd0);
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 5'd0);
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 5'd0);

    // Fill to full, overflow attempt, drain, then wrap.
    for (int i = 1; i <= 5; i++)
      drive(1'b1, 5'(i), 32'h100 + 32'(i), 1'b0, 5'(i), 5'd2);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd4, 5'd5);
    repeat (5) drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 5'd1);
    for (int i = 0; i < 6; i++)
      drive(1'b1, 5'(10 + i), 32'hA00 + 32'(i), 1'(i % 2), 5'(10 + i), 5'(11 + i));
    repeat (6) drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd14, 5'd15);

    // Forwarding priority between duplicate destinations.
    drive(1'b1, 5'd7, 32'hA, 1'b0, 5'd7, 5'd3);
    drive(1'b1, 5'd7, 32'hB, 1'b0, 5'd7, 5'd3);
    drive(1'b1, 5'd3, 32'hC, 1'b0, 5'd7, 5'd3);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd7, 5'd3);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd3);
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 5'd3);
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 5'd3);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd7, 5'd3);
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 5'd3);

    // Zero-register drop, then simultaneous push and pop at count 2.
    drive(1'b1, 5'd0, 32'hFFFF, 1'b0, 5'd0, 5'd0);
    drive(1'b1, 5'd8, 32'h88, 1'b0, 5'd8, 5'd0);
    drive(1'b1, 5'd6, 32'h66, 1'b0, 5'd8, 5'd6);
    drive(1'b1, 5'd9, 32'h99, 1'b1, 5'd9, 5'd8);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd9, 5'd6);
    repeat (3) drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 5'd6);

    // Asynchronous reset while draining three queued entries.
    for (int i = 0; i < 3; i++)
      drive(1'b1, 5'(20 + i), 32'hC0 + 32'(i), 1'b0, 5'd20, 5'd22);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd20, 5'd22);
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd20, 5'd22);
    #2 rst = 1'b0;
    #1;
    chk("rst_rf_we", {31'd0, bus.rf_we}, 32'd0);
    chk("rst_count", {29'd0, bus.count}, 32'd0);
    chk("rst_fwd1", {31'd0, bus.fwd1_hit}, 32'd0);
    sb_q.delete();
    tb_ready = 1'b1;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0);
    rst = 1'b1;
    drive(1'b1, 5'd12, 32'hDEAD_BEEF, 1'b1, 5'd12, 5'd0);
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 5'd0);
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 5'd0);

    // Random traffic over a small register range to provoke hits and duplicates.
    for (int i = 0; i < 600; i++)
      drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
            1'($urandom_range(0, 2) != 0), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    repeat (6) drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd1, 5'd2);
    @(posedge clk);
    #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_write_buffer.md
Name: wb_write_buffer

Overview:
- Write-side companion of the CPU register file.
- Collects register writeback requests in a small FIFO and drains them one per cycle into the register file's single write port (we/wa/wd).
- Provides a combinational forwarding lookup so readers see queued-but-unwritten values.
- Decouples producers (pipeline writeback, multicycle units) from write-port contention signalled by drain_en.

Parameters:
- DEPTH, 4, number of queued write entries; power of two, ≥2.
- AW, 2, pointer width = log2(DEPTH).

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  producer has a write request.
- in_ready  output  1  buffer can accept a request this cycle.
- in_wa  input  5  destination register number.
- in_wd  input  32  write data.
- drain_en  input  1  write port available this cycle.
- rf_we  output  1  write enable to register file.
- rf_wa  output  5  write address to register file.
- rf_wd  output  32  write data to register file.
- ra1  input  5  forwarding lookup address, port 1.
- ra2  input  5  forwarding lookup address, port 2.
- fwd1_hit  output  1  ra1 matches a queued entry.
- fwd1_data  output  32  data of newest matching entry for ra1; 0 when no hit.
- fwd2_hit  output  1  ra2 matches a queued entry.
- fwd2_data  output  32  data of newest matching entry for ra2; 0 when no hit.
- count  output  AW+1  number of valid entries.

Behaviour:
- Reset (rst low, asynchronous): wr_ptr=0, rd_ptr=0, count=0, all entry valid bits cleared. Consequently rf_we=0, fwd*_hit=0, fwd*_data=0, in_ready=1. Entry data need not be cleared.
- in_ready = (count != DEPTH). A full buffer does not accept, even if a pop occurs the same cycle; there is no pass-through.
- push = in_valid & in_ready.
  - If in_wa==0, the request is accepted (handshake completes) but not stored; count and wr_ptr are unchanged.
  - Otherwise, on posedge the entry at wr_ptr ← {in_wa, in_wd}, and wr_ptr increments modulo DEPTH (natural wrap).
- Drain outputs are combinational from the head entry:
  - rf_we = drain_en & (count != 0).
  - rf_wa and rf_wd = head entry at rd_ptr; these are don't-care when rf_we=0 but must not be X in simulation after reset (drive 0 when empty).
- The register file samples its write port on negedge, so a head presented during a cycle is written mid-cycle.
- pop = rf_we. On posedge, rd_ptr increments modulo DEPTH.
- count update on posedge: +1 on stored push only, −1 on pop only, unchanged on both or neither. Simultaneous stored push and pop is legal whenever not full.
- Latency: a stored push in cycle N presents at the head at the earliest in cycle N+1 (empty buffer, drain_en=1). The write reaches the register file on the negedge of cycle N+1.
- Forwarding, combinational:
  - For each port, compare ra against all valid entries; the newest entry (closest to wr_ptr−1) wins.
  - ra==0 never hits.
  - Entries popped at the current posedge stop hitting from the next cycle.
  - The same-cycle in_wa/in_wd input is NOT forwarded.
  - The head entry being written this cycle still hits, which covers the read-before-negedge window.
- Duplicate destinations are legal. Entries drain in order, so the register file ends with the newest value.
- Reset mid-drain: all queued writes are discarded and rf_we deasserts immediately (asynchronous).

Test Plan:
- Reset then idle: rst low 3 cycles, release, all inputs 0 → count=0, in_ready=1, rf_we=0, fwd1_hit=0, fwd2_hit=0.
- Single write: drain_en=1; push {wa=5, wd=0x1234_5678} in cycle 0 → cycle 1: rf_we=1, rf_wa=5, rf_wd=0x12345678, fwd1_hit=1 for ra1=5; cycle 2: count=0, rf_we=0.
- Fill/full/wrap: drain_en=0, push wa=1..5 → first 4 accepted, count=4, in_ready=0 on the 5th; raise drain_en → drains 1,2,3,4 in order; then 6 more pushes wrap pointers correctly, and order is preserved.
- Forwarding priority: drain_en=0, push {7, 0xA}, {7, 0xB}, {3, 0xC} → ra1=7 gives fwd1_data=0xB; ra2=3 gives 0xC; ra1=0 gives no hit; after draining both r7 entries, ra1=7 gives no hit.
- Zero-register drop and simultaneous push/pop: push {0, 0xFFFF} → accepted, count unchanged; with count=2 and drain_en=1, push {9, 0x99} → count stays 2 and the head advances.
- Async reset mid-operation: count=3, drain_en=1, assert rst between edges → rf_we=0 and count=0 immediately; after release, the first push appears at the head normally.
